// File: rtl/bmem_arbiter.sv
// Arbitrates the icache and dcache onto one burst-memory port, turning whole-line
// requests into BEATS-long bmem bursts and assembling read beats back into a line.
`timescale 1ns/1ps
module bmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] bmem_address,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_resp
);
   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = $clog2(BEATS) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {IDLE, RD_CMD, RD_BEAT, WR_BEAT, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              gnt_q, gnt_d;    // 1: dcache owns the transaction
   logic              prio_q, prio_d;  // 1: dcache wins the next contended grant
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              i_req, d_req, pick_d;

   assign i_req   = i_read;
   assign d_req   = d_read | d_write;
   assign i_rdata = line_q;
   assign d_rdata = line_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gnt_d        = gnt_q;
      prio_d       = prio_q;
      addr_d       = addr_q;
      line_d       = line_q;
      pick_d       = 1'b0;
      bmem_read    = 1'b0;
      bmem_write   = 1'b0;
      bmem_wdata   = '0;
      bmem_address = '0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               pick_d = (i_req && d_req) ? prio_q : d_req;
               if (i_req && d_req) prio_d = ~pick_d;
               gnt_d   = pick_d;
               addr_d  = pick_d ? d_addr : i_addr;
               cnt_d   = '0;
               state_d = (pick_d && d_write) ? WR_BEAT : RD_CMD;
            end
         end
         RD_CMD: begin
            bmem_read    = 1'b1;
            bmem_address = addr_q;
            state_d      = RD_BEAT;
         end
         RD_BEAT: begin
            bmem_address = addr_q;
            if (bmem_resp) begin
               line_d[BEAT_W*int'(cnt_q) +: BEAT_W] = bmem_rdata;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) state_d = DONE;
            end
         end
         WR_BEAT: begin
            bmem_write   = 1'b1;
            bmem_address = addr_q;
            bmem_wdata   = d_wdata[BEAT_W*int'(cnt_q) +: BEAT_W];
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            i_resp  = ~gnt_q;
            d_resp  = gnt_q;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gnt_q   <= 1'b0;
         prio_q  <= 1'b1;
         addr_q  <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         prio_q  <= prio_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
      end
   end

   // Read beats are only meaningful while a read burst is collecting them.
   a_resp_in_rd_beat: assert property (@(posedge clk) disable iff (!rst_n)
      bmem_resp |-> (state_q == RD_BEAT));

endmodule
